// File: rtl/spdif_stream_ctrl_pkg.sv
// Shared types and widths for the S/PDIF stream controller.
//   ctrl_state_t : controller state encoding (also driven onto state_out)
//   WATCHDOG_W   : width of the lock-loss watchdog counter
//   CNT_W        : width of the saturating overrun/underrun counters
//   CS_W         : number of channel-status bits qualified for display
//   sat_inc      : saturating increment for CNT_W-wide counters
package spdif_ctrl_pkg;

    localparam int unsigned WATCHDOG_W = 19;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned CS_W       = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOCK    = 3'd1,
        ST_PREFILL = 3'd2,
        ST_STREAM  = 3'd3,
        ST_FLUSH   = 3'd4
    } ctrl_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/spdif_stream_ctrl_toggle_sync.sv
// Toggle-to-pulse crossing from a slower clock domain into clk.
//   clk    : destination clock
//   rst    : synchronous active-high reset, clears all sync flops
//   tgl_in : level that toggles once per event in the source domain
//   req    : one-cycle pulse per toggle, valid in the cycle after the
//            second synchronizer stage captures the new level
module toggle_sync (
    input  logic clk,
    input  logic rst,
    input  logic tgl_in,
    output logic req
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic edge_q,  edge_d;

    always_comb begin
        sync1_d = tgl_in;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
        end
    end

    // Either polarity of toggle is one event.
    assign req = sync2_q ^ edge_q;

endmodule

// File: rtl/spdif_stream_ctrl.sv
// S/PDIF receive-to-retransmit sequencer.
// Gates decoded-sample writes into the sample FIFO, schedules FIFO reads
// against frame requests from the frame assembler, supervises link lock,
// prefill, underrun/overrun and flush, and qualifies the channel-status
// word for the display.
//   clk_60mhz, rst        : clock, synchronous active-high reset
//   sample_valid          : dismantler sample strobe
//   block_done/block_kill : end-of-block pulse and its error flag
//   channel_status        : 192 channel-status bits, valid with block_done
//   fifo_full/empty/prog_empty : sample FIFO flags
//   frame_req_tgl         : frame-request toggle from the 6.144 MHz domain
//   fifo_wr_en/rd_en/srst : FIFO controls
//   stream_active, state_out : status
//   cs_word, cs_valid     : qualified channel-status bits [31:0]
//   overrun_cnt, underrun_cnt : saturating error counters
//   lock_lost             : one-cycle pulse on forced flush
module spdif_stream_ctrl
    import spdif_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_BLOCKS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 300000,
    parameter int unsigned FLUSH_CYCLES   = 4
) (
    input  logic             clk_60mhz,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic             block_done,
    input  logic             block_kill,
    input  logic [191:0]     channel_status,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic             fifo_prog_empty,
    input  logic             frame_req_tgl,
    output logic             fifo_wr_en,
    output logic             fifo_rd_en,
    output logic             fifo_srst,
    output logic             stream_active,
    output logic [2:0]       state_out,
    output logic [CS_W-1:0]  cs_word,
    output logic             cs_valid,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic             lock_lost
);

    localparam logic [3:0]            LOCK_TGT   = 4'(LOCK_BLOCKS);
    localparam logic [3:0]            FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [WATCHDOG_W-1:0] WD_LAST    = WATCHDOG_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_t           state_q, state_d;
    logic [3:0]            lock_cnt_q, lock_cnt_d;
    logic [3:0]            flush_cnt_q, flush_cnt_d;
    logic [WATCHDOG_W-1:0] wd_q, wd_d;
    logic                  rd_en_q, rd_en_d;
    logic                  lock_lost_q, lock_lost_d;
    logic [CS_W-1:0]       cs_prev_q, cs_prev_d;
    logic [CS_W-1:0]       cs_word_q, cs_word_d;
    logic                  cs_valid_q, cs_valid_d;
    logic [CNT_W-1:0]      ovr_q, ovr_d;
    logic [CNT_W-1:0]      und_q, und_d;

    logic req;
    logic good_blk;
    logic bad_blk;
    logic timeout;
    logic streaming;
    logic flush_entry;
    logic unused_cs_hi;

    toggle_sync u_req_sync (
        .clk    (clk_60mhz),
        .rst    (rst),
        .tgl_in (frame_req_tgl),
        .req    (req)
    );

    assign good_blk  = block_done && !block_kill;
    assign bad_blk   = block_done && block_kill;
    // A block arriving on the deadline cycle still proves the link is alive.
    assign timeout   = (wd_q == WD_LAST) && !block_done;
    assign streaming = (state_q == ST_PREFILL) || (state_q == ST_STREAM);
    assign unused_cs_hi = ^channel_status[191:CS_W];

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wd_d        = wd_q;
        rd_en_d     = 1'b0;
        lock_lost_d = 1'b0;
        cs_prev_d   = cs_prev_q;
        cs_word_d   = cs_word_q;
        cs_valid_d  = cs_valid_q;
        ovr_d       = ovr_q;
        und_d       = und_q;

        if ((state_q == ST_IDLE) || (state_q == ST_FLUSH) || block_done) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                lock_cnt_d = '0;
                if (good_blk) begin
                    lock_cnt_d = 4'd1;
                    state_d    = (LOCK_BLOCKS == 1) ? ST_PREFILL : ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (bad_blk) begin
                    lock_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else if (good_blk) begin
                    lock_cnt_d = lock_cnt_q + 4'd1;
                    if (lock_cnt_q + 4'd1 == LOCK_TGT) begin
                        state_d = ST_PREFILL;
                    end
                end else if (timeout) begin
                    lock_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            ST_PREFILL: begin
                if (bad_blk || timeout) begin
                    state_d = ST_FLUSH;
                end else if (!fifo_prog_empty) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // Lock loss wins over a coincident request; the request is dropped.
                if (bad_blk || timeout) begin
                    state_d = ST_FLUSH;
                end else if (req) begin
                    if (fifo_empty) begin
                        und_d   = sat_inc(und_q);
                        state_d = ST_PREFILL;
                    end else begin
                        rd_en_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    flush_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (good_blk && (state_q != ST_FLUSH)) begin
            cs_prev_d = channel_status[CS_W-1:0];
            if (channel_status[CS_W-1:0] == cs_prev_q) begin
                cs_word_d  = channel_status[CS_W-1:0];
                cs_valid_d = 1'b1;
            end else begin
                cs_valid_d = 1'b0;
            end
        end

        flush_entry = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);
        if (flush_entry) begin
            lock_lost_d = 1'b1;
            flush_cnt_d = '0;
            cs_valid_d  = 1'b0;
        end

        if (streaming && sample_valid && fifo_full) begin
            ovr_d = sat_inc(ovr_q);
        end
    end

    always_ff @(posedge clk_60mhz) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lock_cnt_q  <= '0;
            flush_cnt_q <= '0;
            wd_q        <= '0;
            rd_en_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            cs_prev_q   <= '0;
            cs_word_q   <= '0;
            cs_valid_q  <= 1'b0;
            ovr_q       <= '0;
            und_q       <= '0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wd_q        <= wd_d;
            rd_en_q     <= rd_en_d;
            lock_lost_q <= lock_lost_d;
            cs_prev_q   <= cs_prev_d;
            cs_word_q   <= cs_word_d;
            cs_valid_q  <= cs_valid_d;
            ovr_q       <= ovr_d;
            und_q       <= und_d;
        end
    end

    assign fifo_wr_en    = sample_valid && !fifo_full && streaming;
    assign fifo_rd_en    = rd_en_q;
    assign fifo_srst     = (state_q == ST_FLUSH);
    assign stream_active = (state_q == ST_STREAM);
    assign state_out     = state_q;
    assign cs_word       = cs_word_q;
    assign cs_valid      = cs_valid_q;
    assign overrun_cnt   = ovr_q;
    assign underrun_cnt  = und_q;
    assign lock_lost     = lock_lost_q;

endmodule

// File: tb/tb_spdif_stream_ctrl.sv
module tb_spdif_stream_ctrl;

    localparam int TMO = 2000;

    logic         clk_60mhz = 1'b0;
    logic         rst = 1'b1;
    logic         sample_valid = 1'b0;
    logic         block_done = 1'b0;
    logic         block_kill = 1'b0;
    logic [191:0] channel_status = '0;
    logic         fifo_full = 1'b0;
    logic         fifo_empty = 1'b0;
    logic         fifo_prog_empty = 1'b1;
    logic         frame_req_tgl = 1'b0;
    logic         fifo_wr_en;
    logic         fifo_rd_en;
    logic         fifo_srst;
    logic         stream_active;
    logic [2:0]   state_out;
    logic [31:0]  cs_word;
    logic         cs_valid;
    logic [7:0]   overrun_cnt;
    logic [7:0]   underrun_cnt;
    logic         lock_lost;

    spdif_stream_ctrl #(
        .LOCK_BLOCKS    (2),
        .TIMEOUT_CYCLES (TMO),
        .FLUSH_CYCLES   (4)
    ) dut (
        .clk_60mhz       (clk_60mhz),
        .rst             (rst),
        .sample_valid    (sample_valid),
        .block_done      (block_done),
        .block_kill      (block_kill),
        .channel_status  (channel_status),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .fifo_prog_empty (fifo_prog_empty),
        .frame_req_tgl   (frame_req_tgl),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_srst       (fifo_srst),
        .stream_active   (stream_active),
        .state_out       (state_out),
        .cs_word         (cs_word),
        .cs_valid        (cs_valid),
        .overrun_cnt     (overrun_cnt),
        .underrun_cnt    (underrun_cnt),
        .lock_lost       (lock_lost)
    );

    always #5 clk_60mhz = ~clk_60mhz;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Event counters sampled on the falling edge, away from the active edge.
    int unsigned rd_cnt = 0;
    int unsigned rd_empty_cnt = 0;
    int unsigned srst_cnt = 0;
    int unsigned ll_cnt = 0;

    always @(negedge clk_60mhz) begin
        if (fifo_rd_en) rd_cnt++;
        if (fifo_rd_en && fifo_empty) rd_empty_cnt++;
        if (fifo_srst) srst_cnt++;
        if (lock_lost) ll_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_60mhz);
        #1;
    endtask

    // Issue one frame request; rd_en must appear only after the 3rd edge.
    task automatic request(input logic exp_rd);
        frame_req_tgl = ~frame_req_tgl;
        tick();
        check("req_rd_e1", fifo_rd_en, 0);
        tick();
        check("req_rd_e2", fifo_rd_en, 0);
        tick();
        check("req_rd_e3", fifo_rd_en, exp_rd);
        tick();
        check("req_rd_e4", fifo_rd_en, 0);
    endtask

    task automatic good_block(input logic [31:0] cs);
        block_done = 1'b1;
        block_kill = 1'b0;
        channel_status = {160'b0, cs};
        tick();
        block_done = 1'b0;
    endtask

    typedef struct {
        logic        bd;
        logic        bk;
        logic [31:0] cs;
        logic        sv;
        logic        ff;
        logic        pe;
        logic        exp_wr;
        logic [2:0]  exp_st;
        logic        exp_csv;
        logic [31:0] exp_csw;
        logic [7:0]  exp_ovr;
    } vec_t;

    vec_t vt[11];

    initial begin
        int unsigned base_rd, base_srst, base_ll, n;
        logic wr_seen;

        //          bd bk cs            sv ff pe  wr st csv csw           ovr
        vt[0]  = '{0, 0, 32'h0,        1, 0, 1,  0, 0, 0, 32'h0,        8'd0};
        vt[1]  = '{1, 1, 32'h02001904, 0, 0, 1,  0, 0, 0, 32'h0,        8'd0};
        vt[2]  = '{1, 0, 32'h02001904, 0, 0, 1,  0, 1, 0, 32'h0,        8'd0};
        vt[3]  = '{0, 0, 32'h0,        1, 0, 1,  0, 1, 0, 32'h0,        8'd0};
        vt[4]  = '{1, 0, 32'h02001904, 0, 0, 1,  0, 2, 1, 32'h02001904, 8'd0};
        vt[5]  = '{0, 0, 32'h0,        1, 0, 1,  1, 2, 1, 32'h02001904, 8'd0};
        vt[6]  = '{0, 0, 32'h0,        1, 1, 1,  0, 2, 1, 32'h02001904, 8'd1};
        vt[7]  = '{1, 0, 32'h02001905, 0, 0, 1,  0, 2, 0, 32'h02001904, 8'd1};
        vt[8]  = '{0, 0, 32'h0,        0, 0, 0,  0, 3, 0, 32'h02001904, 8'd1};
        vt[9]  = '{0, 0, 32'h0,        1, 0, 0,  1, 3, 0, 32'h02001904, 8'd1};
        vt[10] = '{0, 0, 32'h0,        0, 0, 1,  0, 3, 0, 32'h02001904, 8'd1};

        // Reset state
        repeat (3) tick();
        check("rst_state", state_out, 0);
        check("rst_wr", fifo_wr_en, 0);
        check("rst_rd", fifo_rd_en, 0);
        check("rst_srst", fifo_srst, 0);
        check("rst_active", stream_active, 0);
        check("rst_cs_word", cs_word, 0);
        check("rst_cs_valid", cs_valid, 0);
        check("rst_ovr", overrun_cnt, 0);
        check("rst_und", underrun_cnt, 0);
        check("rst_ll", lock_lost, 0);
        rst = 1'b0;

        // Lock acquisition, prefill, write gating, overrun, CS qualification
        for (int i = 0; i < 11; i++) begin
            block_done      = vt[i].bd;
            block_kill      = vt[i].bk;
            channel_status  = {160'b0, vt[i].cs};
            sample_valid    = vt[i].sv;
            fifo_full       = vt[i].ff;
            fifo_prog_empty = vt[i].pe;
            #1;
            check($sformatf("v%0d_wr", i), fifo_wr_en, vt[i].exp_wr);
            tick();
            check($sformatf("v%0d_state", i), state_out, vt[i].exp_st);
            check($sformatf("v%0d_active", i), stream_active, vt[i].exp_st == 3'd3);
            check($sformatf("v%0d_cs_valid", i), cs_valid, vt[i].exp_csv);
            check($sformatf("v%0d_cs_word", i), cs_word, vt[i].exp_csw);
            check($sformatf("v%0d_ovr", i), overrun_cnt, vt[i].exp_ovr);
        end
        block_done = 1'b0;
        block_kill = 1'b0;
        sample_valid = 1'b0;
        fifo_full = 1'b0;

        // Ten requests with data available
        base_rd = rd_cnt;
        for (int i = 0; i < 10; i++) begin
            request(1'b1);
            tick();
        end
        check("req10_count", rd_cnt - base_rd, 10);
        check("req10_state", state_out, 3);

        // Underrun, then recovery through prefill
        fifo_empty = 1'b1;
        fifo_prog_empty = 1'b1;
        request(1'b0);
        check("und_state", state_out, 2);
        check("und_cnt", underrun_cnt, 1);
        check("und_rd_empty", rd_empty_cnt, 0);
        fifo_empty = 1'b0;
        fifo_prog_empty = 1'b0;
        tick();
        check("und_recover", state_out, 3);

        good_block(32'h02001905);
        check("cs_requal_valid", cs_valid, 1);
        check("cs_requal_word", cs_word, 32'h02001905);

        // Overrun saturation with FIFO full
        fifo_full = 1'b1;
        wr_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            sample_valid = 1'b1;
            #1;
            if (fifo_wr_en) wr_seen = 1'b1;
            tick();
            sample_valid = 1'b0;
            tick();
        end
        fifo_full = 1'b0;
        check("ovr_wr_seen", wr_seen, 0);
        check("ovr_sat", overrun_cnt, 255);
        check("ovr_state", state_out, 3);

        // Simultaneous done+kill in STREAM forces a flush
        base_srst = srst_cnt;
        base_ll = ll_cnt;
        sample_valid = 1'b1;
        block_done = 1'b1;
        block_kill = 1'b1;
        tick();
        block_done = 1'b0;
        block_kill = 1'b0;
        check("kill_state", state_out, 4);
        check("kill_ll", lock_lost, 1);
        check("kill_srst", fifo_srst, 1);
        check("kill_cs_valid", cs_valid, 0);
        check("kill_wr", fifo_wr_en, 0);
        tick();
        check("kill_ll_pulse", lock_lost, 0);
        sample_valid = 1'b0;
        n = 0;
        while (state_out != 3'd0 && n < 20) begin
            tick();
            n++;
        end
        check("kill_idle", state_out, 0);
        check("kill_srst_cycles", srst_cnt - base_srst, 4);
        check("kill_ll_cycles", ll_cnt - base_ll, 1);

        // Watchdog timeout in LOCK returns to IDLE without a flush
        base_srst = srst_cnt;
        base_ll = ll_cnt;
        good_block(32'h02001905);
        check("lto_lock", state_out, 1);
        n = 0;
        while (state_out == 3'd1 && n < TMO + 50) begin
            tick();
            n++;
        end
        check("lto_cycles", n, TMO);
        check("lto_state", state_out, 0);
        check("lto_srst", srst_cnt - base_srst, 0);
        check("lto_ll", ll_cnt - base_ll, 0);

        // Watchdog timeout in STREAM forces a flush
        fifo_prog_empty = 1'b1;
        good_block(32'h02001905);
        good_block(32'h02001905);
        check("sto_prefill", state_out, 2);
        base_srst = srst_cnt;
        base_ll = ll_cnt;
        fifo_prog_empty = 1'b0;
        n = 0;
        while (state_out != 3'd4 && n < TMO + 50) begin
            tick();
            n++;
        end
        check("sto_cycles", n, TMO);
        check("sto_ll", lock_lost, 1);
        n = 0;
        while (state_out != 3'd0 && n < 20) begin
            tick();
            n++;
        end
        check("sto_idle", state_out, 0);
        check("sto_srst_cycles", srst_cnt - base_srst, 4);
        check("sto_ll_cycles", ll_cnt - base_ll, 1);

        // Reset mid-operation
        good_block(32'h02001905);
        check("mrst_lock", state_out, 1);
        rst = 1'b1;
        tick();
        check("mrst_state", state_out, 0);
        check("mrst_srst", fifo_srst, 0);
        check("mrst_ovr", overrun_cnt, 0);
        check("mrst_und", underrun_cnt, 0);
        check("mrst_cs_word", cs_word, 0);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
